// File: rtl/riscv_zero_pkg.sv
// -----------------------------------------------------------------------------
// riscv_zero_pkg
// Shared definitions for the RISC-V Zero decode stage:
//   - RV64I major opcode constants
//   - alu_op_e   : 4-bit ALU operation code driven to execute
//   - imm_type_e : immediate format selector for the immediate generator
//   - ctrl_t     : bundle of single-bit control flags carried by the stage
//   - alu_from_funct3 : funct3/inst[30] -> ALU op mapping for integer ops
// -----------------------------------------------------------------------------
package riscv_zero_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // funct7 value that selects SUB / SRA / SRAI(W) variants
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  typedef struct packed {
    logic alu_src_imm;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic pc_rel;
    logic word_op;
    logic illegal;
  } ctrl_t;

  // Integer ALU op from funct3. inst[30] selects SRA over SRL for every
  // shift form, but only selects SUB for register-register adds (ADDI has
  // no subtract form, so inst[30] is immediate data there).
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3,
                                              input logic       bit30,
                                              input logic       is_reg);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_zero_immgen.sv
// -----------------------------------------------------------------------------
// riscv_zero_immgen
// Combinational immediate generator. Assembles the I/S/B/U/J immediate from
// the instruction word and sign-extends it from inst[31] to XLEN bits.
// Ports:
//   inst_i     [31:0]     instruction word
//   imm_type_i imm_type_e immediate format
//   imm_o      [XLEN-1:0] sign-extended immediate
// -----------------------------------------------------------------------------
module riscv_zero_immgen
  import riscv_zero_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     inst_i,
  input  imm_type_e       imm_type_i,
  output logic [XLEN-1:0] imm_o
);

  // Format select; every format's sign bit is inst[31].
  always_comb begin
    imm_o = '0;
    case (imm_type_i)
      IMM_I: imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
      IMM_S: imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B: imm_o = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7],
                      inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_U: imm_o = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
      IMM_J: imm_o = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12],
                      inst_i[20], inst_i[30:21], 1'b0};
      default: imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    endcase
  end

endmodule

// File: rtl/riscv_zero_decode.sv
// -----------------------------------------------------------------------------
// riscv_zero_decode
// RV64I decode stage of the RISC-V Zero pipeline, with a one-cycle registered
// output bundle for execute.
// Ports:
//   clk, reset_n          clock; synchronous active-low reset
//   pc_in, inst_in        PC and instruction word from fetch
//   in_valid              fetch bundle holds a real instruction
//   stall                 execute cannot accept; hold stage contents
//   flush                 kill the instruction held in this stage
//   in_ready              combinational !stall back to fetch
//   out_valid, pc_out     registered valid and PC
//   rd, rs1, rs2          raw register indices
//   imm                   sign-extended immediate
//   alu_op, funct3        ALU op code and raw funct3
//   alu_src_imm ... illegal  control flags
// Update priority on each posedge: reset > flush > stall > load.
// -----------------------------------------------------------------------------
module riscv_zero_decode
  import riscv_zero_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     inst_in,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  output logic            in_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic [2:0]      funct3,
  output logic            alu_src_imm,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            pc_rel,
  output logic            word_op,
  output logic            illegal
);

  // Instruction fields
  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [4:0]      rd_s;

  // Decode results
  imm_type_e       imm_type_s;
  logic [XLEN-1:0] imm_s;
  alu_op_e         alu_op_s;
  ctrl_t           ctrl_raw_s;
  ctrl_t           ctrl_s;
  logic            bad_enc_s;
  logic            illegal_s;

  // Pipeline register
  logic            valid_q,  valid_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic [4:0]      rd_q,     rd_d;
  logic [4:0]      rs1_q,    rs1_d;
  logic [4:0]      rs2_q,    rs2_d;
  logic [XLEN-1:0] imm_q,    imm_d;
  alu_op_e         alu_op_q, alu_op_d;
  logic [2:0]      funct3_q, funct3_d;
  ctrl_t           ctrl_q,   ctrl_d;

  assign opcode_s = inst_in[6:0];
  assign funct3_s = inst_in[14:12];
  assign funct7_s = inst_in[31:25];
  assign rd_s     = inst_in[11:7];

  riscv_zero_immgen #(
    .XLEN       (XLEN)
  ) u_immgen (
    .inst_i     (inst_in),
    .imm_type_i (imm_type_s),
    .imm_o      (imm_s)
  );

  // Opcode decode: control flags, ALU op, immediate format and encoding checks.
  // alu_src_imm marks every form whose ALU operand B is the immediate
  // (address generation for loads/stores and AUIPC included).
  always_comb begin
    ctrl_raw_s = '0;
    alu_op_s   = ALU_ADD;
    imm_type_s = IMM_I;
    bad_enc_s  = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        alu_op_s               = ALU_PASS_B;
        imm_type_s             = IMM_U;
        ctrl_raw_s.alu_src_imm = 1'b1;
        ctrl_raw_s.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        alu_op_s               = ALU_ADD;
        imm_type_s             = IMM_U;
        ctrl_raw_s.alu_src_imm = 1'b1;
        ctrl_raw_s.reg_write   = 1'b1;
        ctrl_raw_s.pc_rel      = 1'b1;
      end
      OPC_JAL: begin
        imm_type_s           = IMM_J;
        ctrl_raw_s.jump      = 1'b1;
        ctrl_raw_s.reg_write = 1'b1;
      end
      OPC_JALR: begin
        imm_type_s             = IMM_I;
        ctrl_raw_s.jump        = 1'b1;
        ctrl_raw_s.reg_write   = 1'b1;
        ctrl_raw_s.alu_src_imm = 1'b1;
        bad_enc_s              = (funct3_s != 3'b000);
      end
      OPC_BRANCH: begin
        imm_type_s        = IMM_B;
        ctrl_raw_s.branch = 1'b1;
        // funct3 010/011 have no branch condition
        bad_enc_s         = (funct3_s == 3'b010) || (funct3_s == 3'b011);
      end
      OPC_LOAD: begin
        imm_type_s             = IMM_I;
        ctrl_raw_s.mem_read    = 1'b1;
        ctrl_raw_s.reg_write   = 1'b1;
        ctrl_raw_s.alu_src_imm = 1'b1;
        bad_enc_s              = (funct3_s == 3'b111);
      end
      OPC_STORE: begin
        imm_type_s             = IMM_S;
        ctrl_raw_s.mem_write   = 1'b1;
        ctrl_raw_s.alu_src_imm = 1'b1;
        // SB/SH/SW/SD only
        bad_enc_s              = funct3_s[2];
      end
      OPC_OP_IMM: begin
        imm_type_s             = IMM_I;
        ctrl_raw_s.alu_src_imm = 1'b1;
        ctrl_raw_s.reg_write   = 1'b1;
        alu_op_s               = alu_from_funct3(funct3_s, inst_in[30], 1'b0);
        // 6-bit shamt lives in inst[25:20]; inst[31:26] selects the shift kind
        if (funct3_s == 3'b001) begin
          bad_enc_s = (funct7_s[6:1] != 6'b000000);
        end else if (funct3_s == 3'b101) begin
          bad_enc_s = (funct7_s[6:1] != 6'b000000) &&
                      (funct7_s[6:1] != FUNCT7_ALT[6:1]);
        end else begin
          bad_enc_s = 1'b0;
        end
      end
      OPC_OP: begin
        ctrl_raw_s.reg_write = 1'b1;
        alu_op_s             = alu_from_funct3(funct3_s, inst_in[30], 1'b1);
        bad_enc_s = !((funct7_s == 7'b0000000) ||
                      ((funct7_s == FUNCT7_ALT) &&
                       ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
      end
      OPC_OP_IMM_32: begin
        imm_type_s             = IMM_I;
        ctrl_raw_s.alu_src_imm = 1'b1;
        ctrl_raw_s.reg_write   = 1'b1;
        ctrl_raw_s.word_op     = 1'b1;
        alu_op_s               = alu_from_funct3(funct3_s, inst_in[30], 1'b0);
        // *W shifts take a 5-bit shamt, so the full funct7 (incl. inst[25]) is checked
        case (funct3_s)
          3'b000:  bad_enc_s = 1'b0;
          3'b001:  bad_enc_s = (funct7_s != 7'b0000000);
          3'b101:  bad_enc_s = (funct7_s != 7'b0000000) && (funct7_s != FUNCT7_ALT);
          default: bad_enc_s = 1'b1;
        endcase
      end
      OPC_OP_32: begin
        ctrl_raw_s.reg_write = 1'b1;
        ctrl_raw_s.word_op   = 1'b1;
        alu_op_s             = alu_from_funct3(funct3_s, inst_in[30], 1'b1);
        case (funct3_s)
          3'b000,
          3'b101:  bad_enc_s = (funct7_s != 7'b0000000) && (funct7_s != FUNCT7_ALT);
          3'b001:  bad_enc_s = (funct7_s != 7'b0000000);
          default: bad_enc_s = 1'b1;
        endcase
      end
      OPC_MISC_MEM: begin
        // FENCE only: a valid NOP with every flag clear
        bad_enc_s = (funct3_s != 3'b000);
      end
      OPC_SYSTEM: begin
        bad_enc_s = 1'b1;
      end
      default: begin
        bad_enc_s = 1'b1;
      end
    endcase
  end

  // The all-zero word and compressed encodings are rejected on top of opcode checks.
  assign illegal_s = bad_enc_s || (inst_in[1:0] != 2'b11) || (inst_in == 32'h0000_0000);

  // Legality gate: an illegal word carries only the illegal flag; writes to x0 are dropped.
  always_comb begin
    ctrl_s = ctrl_raw_s;
    if (illegal_s) begin
      ctrl_s         = '0;
      ctrl_s.illegal = 1'b1;
    end else begin
      ctrl_s.reg_write = ctrl_raw_s.reg_write && (rd_s != 5'd0);
    end
  end

  // Next-state selection for the stage register: flush beats stall beats load.
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    alu_op_d = alu_op_q;
    funct3_d = funct3_q;
    ctrl_d   = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      valid_d  = in_valid;
      pc_d     = pc_in;
      rd_d     = rd_s;
      rs1_d    = inst_in[19:15];
      rs2_d    = inst_in[24:20];
      imm_d    = imm_s;
      alu_op_d = alu_op_s;
      funct3_d = funct3_s;
      if (in_valid) begin
        ctrl_d = ctrl_s;
      end else begin
        ctrl_d = '0;
      end
    end
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rd_q     <= 5'd0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      imm_q    <= '0;
      alu_op_q <= ALU_ADD;
      funct3_q <= 3'd0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      alu_op_q <= alu_op_d;
      funct3_q <= funct3_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign in_ready    = !stall;
  assign out_valid   = valid_q;
  assign pc_out      = pc_q;
  assign rd          = rd_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign imm         = imm_q;
  assign alu_op      = alu_op_q;
  assign funct3      = funct3_q;
  assign alu_src_imm = ctrl_q.alu_src_imm;
  assign reg_write   = ctrl_q.reg_write;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign branch      = ctrl_q.branch;
  assign jump        = ctrl_q.jump;
  assign pc_rel      = ctrl_q.pc_rel;
  assign word_op     = ctrl_q.word_op;
  assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_riscv_zero_decode.sv
// -----------------------------------------------------------------------------
// tb_riscv_zero_decode
// Scoreboard bench: the driver applies one input set per cycle, advances a
// behavioural model of the stage and queues the expected outputs; a monitor
// pops one entry after every posedge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_riscv_zero_decode;

  logic        clk;
  logic        reset_n;
  logic [63:0] pc_in;
  logic [31:0] inst_in;
  logic        in_valid, stall, flush;
  logic        in_ready, out_valid;
  logic [63:0] pc_out, imm;
  logic [4:0]  rd, rs1, rs2;
  logic [3:0]  alu_op;
  logic [2:0]  funct3;
  logic        alu_src_imm, reg_write, mem_read, mem_write, branch, jump;
  logic        pc_rel, word_op, illegal;

  riscv_zero_decode #(.XLEN(64)) dut (
    .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .inst_in(inst_in),
    .in_valid(in_valid), .stall(stall), .flush(flush), .in_ready(in_ready),
    .out_valid(out_valid), .pc_out(pc_out), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .alu_op(alu_op), .funct3(funct3), .alu_src_imm(alu_src_imm),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .pc_rel(pc_rel), .word_op(word_op),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected stage contents; *chk bits say which fields are defined.
  typedef struct {
    bit          v;
    bit          fchk;
    bit          achk;
    bit          ichk;
    logic [63:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [63:0] imm;
    logic [8:0]  fl;   // {src_imm,reg_write,mem_read,mem_write,branch,jump,pc_rel,word_op,illegal}
  } exp_t;

  exp_t q[$];
  exp_t st;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int n);
    logic signed [63:0] t;
    t = $signed(v << (64 - n));
    return t >>> (64 - n);
  endfunction

  // ALU code for integer ops: table by funct3, then SUB/SRA selected by inst[30].
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input bit b30, input bit is_reg);
    int tab[8];
    tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (f3 == 3'd0 && b30 && is_reg) return 4'd1;
    if (f3 == 3'd5 && b30) return 4'd7;
    return 4'(tab[f3]);
  endfunction

  // Reference decode of one instruction word, straight from the ISA rules.
  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok, src, rw, mr, mw, br, jp, pr, wo, has_alu, has_imm;
    logic [3:0]  alu;
    logic [63:0] im;
    f3 = w[14:12]; f7 = w[31:25];
    ok = 1; src = 0; rw = 0; mr = 0; mw = 0; br = 0; jp = 0; pr = 0; wo = 0;
    has_alu = 0; has_imm = 0; alu = 4'd0; im = 64'd0;
    case (w[6:0])
      7'h37: begin src = 1; rw = 1; has_alu = 1; alu = 4'd10; has_imm = 1; im = sext(64'(w[31:12]), 20) * 64'd4096; end
      7'h17: begin src = 1; rw = 1; pr = 1; has_alu = 1; alu = 4'd0; has_imm = 1; im = sext(64'(w[31:12]), 20) * 64'd4096; end
      7'h6F: begin jp = 1; rw = 1; has_imm = 1; im = sext(64'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21); end
      7'h67: begin jp = 1; rw = 1; src = 1; has_imm = 1; im = sext(64'(w[31:20]), 12); ok = (f3 == 0); end
      7'h63: begin br = 1; has_imm = 1; im = sext(64'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13); ok = (f3 != 2 && f3 != 3); end
      7'h03: begin mr = 1; rw = 1; src = 1; has_imm = 1; im = sext(64'(w[31:20]), 12); ok = (f3 != 7); end
      7'h23: begin mw = 1; src = 1; has_imm = 1; im = sext(64'({w[31:25], w[11:7]}), 12); ok = (f3 < 4); end
      7'h13: begin
        src = 1; rw = 1; has_imm = 1; im = sext(64'(w[31:20]), 12); has_alu = 1; alu = alu_of(f3, w[30], 0);
        if (f3 == 1) ok = (w[31:26] == 6'd0);
        if (f3 == 5) ok = (w[31:26] == 6'd0 || w[31:26] == 6'd16);
      end
      7'h33: begin
        rw = 1; has_alu = 1; alu = alu_of(f3, w[30], 1);
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      end
      7'h1B: begin
        src = 1; rw = 1; wo = 1; has_imm = 1; im = sext(64'(w[31:20]), 12); has_alu = 1; alu = alu_of(f3, w[30], 0);
        ok = (f3 == 0) || (f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 7'h20));
      end
      7'h3B: begin
        rw = 1; wo = 1; has_alu = 1; alu = alu_of(f3, w[30], 1);
        ok = ((f3 == 0 || f3 == 5) && (f7 == 0 || f7 == 7'h20)) || (f3 == 1 && f7 == 0);
      end
      7'h0F: ok = (f3 == 0);
      default: ok = 0;
    endcase
    if (w == 32'd0 || w[1:0] != 2'b11) ok = 0;
    e.v = 1; e.fchk = 1; e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = f3;
    e.alu = alu; e.imm = im;
    if (!ok) begin
      e.fl = 9'b0_0000_0001; e.achk = 0; e.ichk = 0;
    end else begin
      e.fl = {src, rw && (w[11:7] != 5'd0), mr, mw, br, jp, pr, wo, 1'b0};
      e.achk = has_alu; e.ichk = has_imm;
    end
    return e;
  endfunction

  function automatic exp_t reset_state();
    exp_t e;
    e.v = 0; e.fchk = 1; e.achk = 1; e.ichk = 1; e.pc = 64'd0; e.rd = 5'd0; e.rs1 = 5'd0;
    e.rs2 = 5'd0; e.f3 = 3'd0; e.alu = 4'd0; e.imm = 64'd0; e.fl = 9'd0;
    return e;
  endfunction

  // Applies one cycle of inputs (called at a negedge), advances the model and
  // queues the state expected after the coming posedge.
  task automatic apply(input bit rst_n, input bit v, input logic [31:0] w,
                       input logic [63:0] pc, input bit stl, input bit fl);
    reset_n = rst_n; in_valid = v; inst_in = w; pc_in = pc; stall = stl; flush = fl;
    #1;
    chk("in_ready", 64'(in_ready), 64'(!stl));
    if (!rst_n) st = reset_state();
    else if (fl) begin st.v = 0; st.fl = 9'd0; st.fchk = 0; st.achk = 0; st.ichk = 0; end
    else if (stl) begin end
    else if (v) st = model(w, pc);
    else begin st.v = 0; st.fl = 9'd0; st.fchk = 0; st.achk = 0; st.ichk = 0; end
    q.push_back(st);
    @(negedge clk);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("out_valid", 64'(out_valid), 64'(e.v));
      chk("flags", 64'({alu_src_imm, reg_write, mem_read, mem_write, branch, jump, pc_rel, word_op, illegal}), 64'(e.fl));
      if (e.fchk) begin
        chk("pc_out", pc_out, e.pc);
        chk("rd", 64'(rd), 64'(e.rd));
        chk("rs1", 64'(rs1), 64'(e.rs1));
        chk("rs2", 64'(rs2), 64'(e.rs2));
        chk("funct3", 64'(funct3), 64'(e.f3));
      end
      if (e.fchk && e.achk) chk("alu_op", 64'(alu_op), 64'(e.alu));
      if (e.fchk && e.ichk) chk("imm", imm, e.imm);
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  f7s[5];
    logic [6:0]  ops[13];
    int k;
    f7s = '{7'h00, 7'h01, 7'h20, 7'h21, 7'h00};
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h0F, 7'h73};
    w = $urandom();
    k = $urandom_range(0, 13);
    if (k == 13) return w;
    w[6:0] = ops[k];
    if (k == 3 && $urandom_range(0, 3) != 0) w[14:12] = 3'd0;
    if (k >= 7 && k <= 10) begin
      f7s[4] = 7'($urandom());
      w[31:25] = f7s[$urandom_range(0, 4)];
    end
    return w;
  endfunction

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; inst_in = 32'd0; pc_in = 64'd0; stall = 1'b0; flush = 1'b0;
    st = reset_state();
    @(negedge clk);

    // Reset state
    apply(0, 0, 32'd0, 64'd0, 0, 0);
    apply(0, 1, 32'h00500093, 64'h40, 1, 1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_alu", 64'(alu_op), 64'd0);
    chk("rst_pc", pc_out, 64'd0);

    // addi x1,x0,5
    apply(1, 1, 32'h00500093, 64'h100, 0, 0);
    chk("addi_rd", 64'(rd), 64'd1);
    chk("addi_imm", imm, 64'd5);
    chk("addi_ctl", 64'({out_valid, alu_src_imm, reg_write}), 64'b111);

    // sw x2,-4(x1)
    apply(1, 1, 32'hFE20AE23, 64'h104, 0, 0);
    chk("sw_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sw_ctl", 64'({mem_write, reg_write}), 64'b10);

    // beq x0,x0,-8
    apply(1, 1, 32'hFE000CE3, 64'h1000, 0, 0);
    chk("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("beq_pc", pc_out, 64'h1000);

    // Stall holds the addi while the input changes
    apply(1, 1, 32'h00500093, 64'h200, 0, 0);
    for (int i = 0; i < 3; i++) apply(1, 1, 32'h00000013, 64'h204, 1, 0);
    chk("stall_imm", imm, 64'd5);
    apply(1, 1, 32'h00000013, 64'h204, 0, 0);
    chk("unstall_pc", pc_out, 64'h204);

    // Flush wins over stall; reset mid-stream
    apply(1, 1, 32'h00500093, 64'h300, 1, 1);
    apply(1, 1, 32'h00500093, 64'h300, 0, 0);
    apply(0, 1, 32'h00500093, 64'h304, 0, 0);
    chk("midrst_rd", 64'(rd), 64'd0);

    // Illegal encodings
    apply(1, 1, 32'h00000000, 64'h400, 0, 0);
    apply(1, 1, 32'h04009093, 64'h404, 0, 0);
    chk("slli_bad", 64'({illegal, out_valid, reg_write, mem_write}), 64'b1100);
    apply(1, 1, 32'h4210D09B, 64'h408, 0, 0);
    chk("sraiw_bad", 64'(illegal), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      apply($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, rand_inst(),
            {$urandom(), $urandom()}, $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
    end

    @(posedge clk);
    #3;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_zero_decode.md
Name: riscv_zero_decode

Overview:
Decode stage of the RISC-V Zero pipeline. Sits directly downstream of fetch and consumes its PC and 32-bit instruction word. Decodes RV64I into register indices, a sign-extended 64-bit immediate, an ALU op and control bits. Results are held in a registered pipeline stage with valid/stall/flush control for execute.

Parameters:
XLEN, 64, datapath and PC width; the immediate is sign-extended to XLEN.

Ports:
clk  input  1  clock; all state updates on posedge
reset_n  input  1  synchronous, active-low reset
pc_in  input  XLEN  PC of the instruction from fetch
inst_in  input  32  instruction word from fetch
in_valid  input  1  pc_in/inst_in hold a real instruction
stall  input  1  execute cannot accept; hold stage contents
flush  input  1  branch taken; kill the instruction in this stage
in_ready  output  1  combinational, equals !stall
out_valid  output  1  decoded bundle valid
pc_out  output  XLEN  registered PC
rd, rs1, rs2  output  5 each  register indices
imm  output  XLEN  sign-extended immediate
alu_op  output  4  ALU operation code (package enum)
funct3  output  3  raw funct3, used for load/store size and branch condition
alu_src_imm, reg_write, mem_read, mem_write, branch, jump, pc_rel, word_op, illegal  output  1 each  control flags

Behaviour:
- Reset (reset_n=0 at posedge): every registered output is 0, and alu_op=ALU_ADD (0). Reset overrides stall and flush. A reset mid-stream drops the held instruction.
- Latency: 1 cycle. A bundle captured at posedge N is visible after posedge N.
- Per-posedge priority: reset > flush > stall > load.
  - flush=1: out_valid<=0 and all control flags <=0, even when stall=1. Other fields are don't-care.
  - stall=1 (no flush): all outputs hold their values, and inputs are ignored.
  - Otherwise: out_valid<=in_valid. If in_valid=0, control flags <=0.
- Immediates, sign-extended from the top bit:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- Decode by opcode:
  - LUI: alu_op=PASS_B, alu_src_imm=1.
  - AUIPC: ADD, pc_rel=1.
  - JAL and JALR: jump=1, reg_write=1. JALR also has alu_src_imm=1.
  - BRANCH: branch=1.
  - LOAD: mem_read=1, reg_write=1.
  - STORE: mem_write=1.
  - OP-IMM, OP, OP-IMM-32, OP-32: ALU op from funct3 plus inst[30]. The *-32 variants set word_op=1.
  - MISC-MEM (FENCE): valid NOP with all flags 0.
- Shifts:
  - RV64 SLLI/SRLI/SRAI use the 6-bit shamt inst[25:20]. imm[11:6] must be 000000, or 010000 for SRAI.
  - *W shifts additionally require inst[25]=0.
- illegal=1 for any of the following:
  - an unknown opcode, including SYSTEM;
  - inst[1:0]!=11;
  - an invalid funct3/funct7 combination;
  - inst_in==0.
- When illegal=1: out_valid still asserts and all write/mem/branch/jump flags are 0.
- reg_write is forced to 0 when rd==0.
- rs2 and rs1 are always extracted raw; consumers ignore unused indices.

Decomposition:
- Package riscv_zero_pkg holds:
  - opcode constants (OPC_LUI ... OPC_SYSTEM);
  - the 4-bit alu_op enum: ADD=0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B;
  - the imm-type enum (I, S, B, U, J).
- One combinational sub-module, riscv_zero_immgen (inst, imm_type -> imm), is natural. The remaining decode and the pipeline register stay in riscv_zero_decode.

Test Plan:
- addi x1,x0,5 (0x00500093), in_valid=1 -> next cycle: rd=1, rs1=0, imm=5, alu_op=ADD, alu_src_imm=1, reg_write=1, out_valid=1.
- sw x2,-4(x1) (0xFE20AE23) -> imm=0xFFFFFFFFFFFFFFFC, rs1=1, rs2=2, funct3=010, mem_write=1, reg_write=0.
- beq x0,x0,-8 (0xFE000CE3), pc_in=0x1000 -> branch=1, imm=0xFFFFFFFFFFFFFFF8, pc_out=0x1000.
- Load addi, then stall=1 for 3 cycles while inst_in changes to 0x00000013 -> outputs unchanged and in_ready=0. Release stall -> the new bundle appears one cycle later.
- stall=1 and flush=1 together -> out_valid=0 and all flags 0 next cycle. Drive reset_n=0 mid-stream -> all outputs 0 at the next posedge.
- inst_in=0x00000000, then slli x1,x1,64 with a bad imm[11:6] (0x04009093) -> illegal=1, out_valid=1, reg_write=0, mem_write=0. sraiw with inst[25]=1 -> illegal=1.
